// File: rtl/aes256_cipher_core.sv
// Iterative AES-256 encryption core: one round per clock, valid/ready in and out.
// The round-key schedule is read directly from the keyschedule port and is not stored here.
module aes256_cipher_core (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [0:127]   plaintext,
    input  logic [0:1919]  keyschedule,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [0:127]   ciphertext
);
    localparam int unsigned NR = 14;

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [0:127] state_q, state_d;

    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [0:127] sr_flat;
    logic [0:127] mc_flat;
    logic [0:127] rk;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes, ShiftRows (row r rotated left by r), then MixColumns on the shifted state
    always_comb begin
        for (int k = 0; k < 16; k++) begin
            sb[k] = sbox(state_q[8*k +: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
            end
        end
        sr_flat = '0;
        mc_flat = '0;
        for (int k = 0; k < 16; k++) begin
            sr_flat[8*k +: 8] = sr[k];
        end
        for (int c = 0; c < 4; c++) begin
            mc_flat[32*c +: 8]      = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1]
                                      ^ sr[4*c+2] ^ sr[4*c+3];
            mc_flat[32*c + 8 +: 8]  = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2])
                                      ^ sr[4*c+2] ^ sr[4*c+3];
            mc_flat[32*c + 16 +: 8] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2])
                                      ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc_flat[32*c + 24 +: 8] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1]
                                      ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
        rk = keyschedule[{rnd_q, 7'b0000000} +: 128];
    end

    always_comb begin
        fsm_d   = fsm_q;
        rnd_d   = rnd_q;
        state_d = state_q;
        unique case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = plaintext ^ keyschedule[0 +: 128];
                    rnd_d   = 4'd1;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                // Final round skips MixColumns
                if (rnd_q == 4'(NR)) begin
                    state_d = sr_flat ^ rk;
                    fsm_d   = DONE;
                end else begin
                    state_d = mc_flat ^ rk;
                    rnd_d   = rnd_q + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            rnd_q   <= 4'd0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            state_q <= state_d;
        end
    end

    assign in_ready   = (fsm_q == IDLE) && !rst;
    assign out_valid  = (fsm_q == DONE);
    assign ciphertext = state_q;
endmodule

// File: tb/tb_aes256_cipher_core.sv
// Directed bench for aes256_cipher_core: known-answer vectors, backpressure, ignored input,
// mid-operation reset and back-to-back blocks.
module tb_aes256_cipher_core;
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [0:127] PT_C3  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [0:255] KEY_SP = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [0:127] PT_SP  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [0:127] CT_SP  = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
    localparam logic [0:127] CT_Z   = 128'hdc95c078a2408989ad48a21492842087;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [0:127]  plaintext;
    logic [0:1919] keyschedule;
    logic          out_valid;
    logic          out_ready;
    logic [0:127]  ciphertext;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int lat;
    int t_a;
    int t_b;

    aes256_cipher_core dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .keyschedule(keyschedule),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[int'(b)*8 +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // FIPS-197 key expansion for Nk = 8, Nr = 14
    function automatic logic [0:1919] expand(input logic [0:255] key);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [0:1919] ks;
        for (int i = 0; i < 8; i++) w[i] = key[32*i +: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = {rc[6:0], 1'b0};
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int i = 0; i < 60; i++) ks[32*i +: 32] = w[i];
        return ks;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one block for a single cycle; returns just after the accept edge
    task automatic accept(input logic [0:127] pt, output int t_acc);
        plaintext = pt;
        in_valid  = 1'b1;
        tick();
        t_acc     = cyc;
        in_valid  = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        plaintext   = '0;
        keyschedule = '0;
        #3;
        chk("reset_in_ready", 128'(in_ready), 128'd0);
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_ciphertext", ciphertext, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 128'(in_ready), 128'd1);
        tick();

        // FIPS-197 C.3 with out_ready held high
        keyschedule = expand(KEY_C3);
        accept(PT_C3, t_a);
        wait_out(lat);
        chk("c3_latency", 128'(lat), 128'd14);
        chk("c3_ct", ciphertext, CT_C3);
        tick();
        chk("c3_post_out_valid", 128'(out_valid), 128'd0);
        chk("c3_post_in_ready", 128'(in_ready), 128'd1);

        // All-zero key/plaintext under 20 cycles of backpressure
        keyschedule = expand(256'd0);
        out_ready   = 1'b0;
        accept(128'd0, t_a);
        wait_out(lat);
        chk("zero_latency", 128'(lat), 128'd14);
        chk("zero_ct", ciphertext, CT_Z);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_ct", ciphertext, CT_Z);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_out_valid", 128'(out_valid), 128'd0);
        chk("bp_release_in_ready", 128'(in_ready), 128'd1);

        // SP800-38A vector while in_valid/plaintext toggle during the rounds
        keyschedule = expand(KEY_SP);
        accept(PT_SP, t_a);
        for (int i = 0; i < 10; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            plaintext = {$urandom, $urandom, $urandom, $urandom};
            chk("ign_in_ready", 128'(in_ready), 128'd0);
            tick();
        end
        in_valid = 1'b0;
        wait_out(lat);
        chk("ign_latency", 128'(lat + 10), 128'd14);
        chk("ign_ct", ciphertext, CT_SP);
        tick();

        // Reset asserted while rnd = 7
        keyschedule = expand(KEY_C3);
        accept(PT_C3, t_a);
        repeat (6) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'd0);
        chk("midrst_in_ready", 128'(in_ready), 128'd0);
        chk("midrst_ct", ciphertext, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_release_in_ready", 128'(in_ready), 128'd1);
        tick();
        accept(PT_C3, t_a);
        wait_out(lat);
        chk("rerun_latency", 128'(lat), 128'd14);
        chk("rerun_ct", ciphertext, CT_C3);
        tick();

        // Back-to-back: C.3 then SP800-38A, accepts 16 cycles apart
        accept(PT_C3, t_a);
        wait_out(lat);
        chk("b2b1_latency", 128'(lat), 128'd14);
        chk("b2b1_ct", ciphertext, CT_C3);
        tick();
        chk("b2b_in_ready", 128'(in_ready), 128'd1);
        keyschedule = expand(KEY_SP);
        accept(PT_SP, t_b);
        chk("b2b_spacing", 128'(t_b - t_a), 128'd16);
        wait_out(lat);
        chk("b2b2_latency", 128'(lat), 128'd14);
        chk("b2b2_ct", ciphertext, CT_SP);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/aes256_cipher_core.md
# aes256_cipher_core

Iterative AES-256 encryption datapath computing one round per clock. Sits directly downstream of the 256-bit key-expansion stage: it consumes the 1920-bit round-key schedule produced there, together with a 128-bit plaintext block, and emits the 128-bit ciphertext over a valid/ready handshake.

## Interface

- No parameters; Nr = 14 and the block width of 128 bits are fixed.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  plaintext/keyschedule offered.
- in_ready  out  1  block can accept; high only in IDLE and while rst is low.
- plaintext  in  [0:127]  input block; byte k = bits [8k +: 8], state row k%4, column k/4.
- keyschedule  in  [0:1919]  60 words; round key r = bits [128r +: 128].
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  consumer accepts ciphertext.
- ciphertext  out  [0:127]  result, same byte ordering as plaintext.

## Operation

- FSM states: IDLE, ROUND, DONE. Round counter rnd is 4 bits, range 1..14.
- IDLE: in_ready=1. On in_valid & in_ready: state <= plaintext ^ rk0; rnd <= 1; go to ROUND.
- ROUND, rnd 1..13: state <= MixColumns(ShiftRows(SubBytes(state))) ^ rk[rnd]; rnd <= rnd+1.
- ROUND, rnd 14: state <= ShiftRows(SubBytes(state)) ^ rk14, with no MixColumns; go to DONE.
- DONE: out_valid=1 and ciphertext=state. Both stay stable until out_ready. On out_valid & out_ready go to IDLE and drop out_valid.
- SubBytes uses the standard FIPS-197 S-box on all 16 bytes in parallel.
- ShiftRows rotates row i left by i columns.
- MixColumns uses the fixed polynomial {03}x^3+{01}x^2+{01}x+{02}. xtime reduces by 0x1b.
- The keyschedule is not latched. Upstream holds it stable from the accept edge until the out_valid & out_ready edge. Changes outside that window are ignored.
- in_valid asserted while not in IDLE is ignored: no capture, no error.
- Inputs are not consumed without a handshake. plaintext may change freely once accepted.

## Timing

- Reset, asynchronous and immediate: FSM=IDLE, rnd=0, state=0, out_valid=0, ciphertext=0, in_ready=0 while rst is high.
- After rst deasserts, in_ready=1 combinationally from IDLE.
- Latency: accept at edge E0. Rounds occur at edges E1..E14. out_valid rises after E14, i.e. 14 cycles after accept.
- Throughput: one block per 16 cycles minimum. This is accept + 14 rounds + 1 IDLE cycle, when out_ready is held high; the DONE state lasts exactly one cycle in that case.
- out_ready low holds DONE indefinitely, with ciphertext unchanged.
- No accept is possible in the same cycle as the output handshake. in_ready rises the cycle after it.
- rst mid-operation (ROUND or DONE): the block aborts immediately. out_valid=0, there is no partial output, and the next accept starts cleanly.
- Back-to-back: a new block accepted in the first IDLE cycle after DONE yields its correct result with no state carry-over.

## Test plan

- FIPS-197 C.3: keyschedule = expansion of key 000102…1e1f; plaintext 00112233445566778899aabbccddeeff -> ciphertext 8ea2b7ca516745bfeafc49904b496089, with out_valid exactly 14 cycles after accept.
- SP800-38A ECB-AES256: key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4; plaintext 6bc1bee22e409f96e93d7e117393172a -> f3eed1bdb5d2a03c064b5a7e3db181f8.
- All-zero key and all-zero plaintext -> dc95c078a2408989ad48a21492842087.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> ciphertext and out_valid remain stable and in_ready stays 0; raise out_ready -> IDLE the next cycle.
- Ignored input: toggle in_valid with random plaintext during ROUND -> result for the first block is unchanged.
- Mid-operation reset: assert rst at round 7 -> out_valid=0, in_ready=0 immediately. Release rst and rerun the C.3 vector -> correct ciphertext.
- Back-to-back: send C.3 then SP800-38A with out_ready=1 -> both results are correct and the two accepts are 16 cycles apart.
